// File: rtl/can_pkg.sv
// Shared constants, encodings and helpers for the CAN / CAN FD CRC block.
package can_pkg;

  localparam int unsigned W15 = 15;
  localparam int unsigned W17 = 17;
  localparam int unsigned W21 = 21;

  localparam logic [14:0] Poly15 = 15'h4599;
  localparam logic [16:0] Poly17 = 17'h1685B;
  localparam logic [20:0] Poly21 = 21'h102899;

  // CAN FD seeds have only the MSB set; classic CAN uses zero seeds.
  localparam logic [16:0] Seed17Fd = 17'h10000;
  localparam logic [20:0] Seed21Fd = 21'h100000;

  typedef enum logic [1:0] {
    SelCrc15 = 2'd0,
    SelCrc17 = 2'd1,
    SelCrc21 = 2'd2,
    SelRsvd  = 2'd3
  } crc_sel_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StCheck,
    StDone
  } state_e;

  // One serial LFSR step on a zero-extended register of the given width.
  function automatic logic [20:0] crc_next(input logic [20:0] cur, input logic din,
                                           input logic [20:0] poly, input int unsigned width);
    logic [20:0] mask;
    logic        fb;
    mask = (21'd1 << width) - 21'd1;
    fb   = din ^ (|(cur & (21'd1 << (width - 1))));
    return ((cur << 1) ^ (fb ? poly : 21'd0)) & mask;
  endfunction

  // Number of CRC-field bits for a (resolved) selection.
  function automatic logic [4:0] sel_width(input crc_sel_e sel);
    case (sel)
      SelCrc17: return 5'd17;
      SelCrc21: return 5'd21;
      default:  return 5'd15;
    endcase
  endfunction

endpackage

// File: rtl/can_crc_lfsr.sv
// Serial CRC LFSR: seedable, shifts one destuffed bit per enabled cycle.
module can_crc_lfsr #(
  parameter int unsigned  W    = 15,
  parameter logic [W-1:0] POLY = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         seed_load,
  input  logic [W-1:0] seed,
  input  logic         shift,
  input  logic         din,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  logic         fb;

  // Next value: shift left, fold in polynomial when feedback is set.
  always_comb begin
    fb  = din ^ q_q[W-1];
    q_d = {q_q[W-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

  // Register: reset beats seed beats shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else if (seed_load) begin
      q_q <= seed;
    end else if (shift) begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/can_fd_crc.sv
// CAN / CAN FD CRC generator and checker: three LFSRs, frame FSM, capture and check.
module can_fd_crc
  import can_pkg::*;
#(
  parameter bit EN_CRC17 = 1'b1,
  parameter bit EN_CRC21 = 1'b1,
  parameter bit FD_INIT  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_tick,
  input  logic        crc_enable,
  input  logic        start,
  input  logic        chk_start,
  input  logic        abort,
  input  logic [1:0]  crc_sel,
  input  logic        data_in,
  output logic [14:0] crc15,
  output logic [16:0] crc17,
  output logic [20:0] crc21,
  output logic [20:0] crc_out,
  output logic        busy,
  output logic        done,
  output logic        crc_ok
);

  localparam logic [16:0] Seed17 = FD_INIT ? Seed17Fd : 17'd0;
  localparam logic [20:0] Seed21 = FD_INIT ? Seed21Fd : 21'd0;

  state_e      state_q, state_d;
  crc_sel_e    sel_q, sel_d, sel_eff;
  logic [4:0]  cnt_q, cnt_d;
  logic [20:0] crc_out_q, crc_out_d;
  logic        done_q, done_d;
  logic        crc_ok_q, crc_ok_d;

  logic        tick_en, seed_load, calc_shift, check_shift;
  logic        shift15, shift17, shift21;
  logic [20:0] nxt15, nxt17, nxt21, cap_val, chk_nxt;

  assign tick_en     = bit_tick & crc_enable;
  assign seed_load   = start & ~abort;
  assign calc_shift  = (state_q == StCalc) & tick_en & ~abort & ~start;
  assign check_shift = (state_q == StCheck) & tick_en & ~abort & ~start;
  assign shift15     = calc_shift | (check_shift & (sel_q == SelCrc15));
  assign shift17     = calc_shift | (check_shift & (sel_q == SelCrc17));
  assign shift21     = calc_shift | (check_shift & (sel_q == SelCrc21));

  can_crc_lfsr #(
    .W    (W15),
    .POLY (Poly15)
  ) u_crc15 (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .seed      (15'd0),
    .shift     (shift15),
    .din       (data_in),
    .q         (crc15)
  );

  if (EN_CRC17) begin : g_crc17
    can_crc_lfsr #(
      .W    (W17),
      .POLY (Poly17)
    ) u_crc17 (
      .clk       (clk),
      .rst       (rst),
      .seed_load (seed_load),
      .seed      (Seed17),
      .shift     (shift17),
      .din       (data_in),
      .q         (crc17)
    );
  end else begin : g_no_crc17
    assign crc17 = '0;
  end

  if (EN_CRC21) begin : g_crc21
    can_crc_lfsr #(
      .W    (W21),
      .POLY (Poly21)
    ) u_crc21 (
      .clk       (clk),
      .rst       (rst),
      .seed_load (seed_load),
      .seed      (Seed21),
      .shift     (shift21),
      .din       (data_in),
      .q         (crc21)
    );
  end else begin : g_no_crc21
    assign crc21 = '0;
  end

  // Resolve crc_sel; reserved or disabled selections fall back to CRC-15.
  always_comb begin
    sel_eff = SelCrc15;
    case (crc_sel)
      2'd1:    if (EN_CRC17) sel_eff = SelCrc17;
      2'd2:    if (EN_CRC21) sel_eff = SelCrc21;
      default: sel_eff = SelCrc15;
    endcase
  end

  // Post-shift LFSR values, so a tick coinciding with capture/check is included.
  always_comb begin
    nxt15   = crc_next({6'd0, crc15}, data_in, {6'd0, Poly15}, W15);
    nxt17   = crc_next({4'd0, crc17}, data_in, {4'd0, Poly17}, W17);
    nxt21   = crc_next(crc21, data_in, Poly21, W21);
    cap_val = {6'd0, crc15};
    case (sel_eff)
      SelCrc17: cap_val = calc_shift ? nxt17 : {4'd0, crc17};
      SelCrc21: cap_val = calc_shift ? nxt21 : crc21;
      default:  cap_val = calc_shift ? nxt15 : {6'd0, crc15};
    endcase
    case (sel_q)
      SelCrc17: chk_nxt = nxt17;
      SelCrc21: chk_nxt = nxt21;
      default:  chk_nxt = nxt15;
    endcase
  end

  // FSM next state, bit counter, capture and check result.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    crc_out_d = crc_out_q;
    done_d    = 1'b0;
    crc_ok_d  = crc_ok_q;
    if (abort) begin
      state_d  = StIdle;
      crc_ok_d = 1'b0;
    end else if (start) begin
      state_d  = StCalc;
      cnt_d    = 5'd0;
      crc_ok_d = 1'b0;
    end else begin
      case (state_q)
        StCalc: begin
          if (chk_start) begin
            sel_d     = sel_eff;
            crc_out_d = cap_val;
            cnt_d     = 5'd0;
            state_d   = StCheck;
          end
        end
        StCheck: begin
          if (tick_en) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_d == sel_width(sel_q)) begin
              state_d  = StDone;
              done_d   = 1'b1;
              crc_ok_d = (chk_nxt == 21'd0);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sel_q     <= SelCrc15;
      cnt_q     <= 5'd0;
      crc_out_q <= 21'd0;
      done_q    <= 1'b0;
      crc_ok_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      crc_out_q <= crc_out_d;
      done_q    <= done_d;
      crc_ok_q  <= crc_ok_d;
    end
  end

  assign crc_out = crc_out_q;
  assign busy    = (state_q == StCalc) || (state_q == StCheck);
  assign done    = done_q;
  assign crc_ok  = crc_ok_q;

endmodule

// File: tb/tb_can_fd_crc.sv
// Self-checking bench for can_fd_crc against a bit-serial CRC reference model.
module tb_can_fd_crc;

  logic        clk = 1'b0;
  logic        rst, bit_tick, crc_enable, start, chk_start, abort, data_in;
  logic [1:0]  crc_sel;
  logic [14:0] crc15;
  logic [16:0] crc17;
  logic [20:0] crc21, crc_out;
  logic        busy, done, crc_ok;

  int n_vec = 0;
  int n_bad = 0;

  can_fd_crc dut (
    .clk        (clk),
    .rst        (rst),
    .bit_tick   (bit_tick),
    .crc_enable (crc_enable),
    .start      (start),
    .chk_start  (chk_start),
    .abort      (abort),
    .crc_sel    (crc_sel),
    .data_in    (data_in),
    .crc15      (crc15),
    .crc17      (crc17),
    .crc21      (crc21),
    .crc_out    (crc_out),
    .busy       (busy),
    .done       (done),
    .crc_ok     (crc_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: CRC as defined bit by bit from seed, polynomial and width.
  function automatic int wid(input int s);
    return (s == 1) ? 17 : (s == 2) ? 21 : 15;
  endfunction

  function automatic logic [20:0] poly_of(input int s);
    return (s == 1) ? 21'h1685B : (s == 2) ? 21'h102899 : 21'h4599;
  endfunction

  function automatic logic [20:0] seed_of(input int s);
    return (s == 1) ? 21'h10000 : (s == 2) ? 21'h100000 : 21'h0;
  endfunction

  function automatic logic [20:0] ref_crc(input int s, input bit bits[$]);
    int          w;
    logic [20:0] r;
    logic [20:0] top;
    w   = wid(s);
    r   = seed_of(s);
    top = 21'd1 << (w - 1);
    foreach (bits[i]) begin
      if (bits[i] ^ ((r & top) != 0)) r = ((r << 1) ^ poly_of(s)) & ((top << 1) - 21'd1);
      else r = (r << 1) & ((top << 1) - 21'd1);
    end
    return r;
  endfunction

  function automatic logic [20:0] dut_reg(input int s);
    return (s == 1) ? {4'd0, crc17} : (s == 2) ? crc21 : {6'd0, crc15};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit b, input bit en);
    bit_tick = 1'b1; crc_enable = en; data_in = b;
    cyc();
    bit_tick = 1'b0; crc_enable = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_chk(input logic [1:0] sel);
    chk_start = 1'b1; crc_sel = sel;
    cyc();
    chk_start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
  endtask

  bit          pay[$];
  bit          msg[$];
  bit          b;
  logic [20:0] exp_crc, r0, r1, r2;
  string       digits;
  logic [7:0]  ch;
  int          sm, w, fpos;
  logic        flip;

  initial begin
    rst = 1'b1; bit_tick = 0; crc_enable = 0; start = 0; chk_start = 0; abort = 0;
    data_in = 0; crc_sel = 2'd0;
    cyc(); cyc();
    check("rst_crc15", 32'(crc15), 0);
    check("rst_crc17", 32'(crc17), 0);
    check("rst_crc21", 32'(crc21), 0);
    check("rst_crc_out", crc_out, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_crc_ok", 32'(crc_ok), 0);
    rst = 1'b0;
    cyc();

    // Seeding and the classic "123456789" check value.
    pulse_start();
    check("seed_crc15", 32'(crc15), 0);
    check("seed_crc17", 32'(crc17), 32'h10000);
    check("seed_crc21", 32'(crc21), 32'h100000);
    check("seed_busy", 32'(busy), 1);
    digits = "123456789";
    msg = {};
    for (int i = 0; i < 9; i++) begin
      ch = digits[i];
      for (int j = 7; j >= 0; j--) begin
        send(ch[j], 1'b1);
        msg.push_back(ch[j]);
      end
    end
    check("ascii_crc15", 32'(crc15), 32'h059E);
    check("ascii_crc17", 32'(crc17), 32'(ref_crc(1, msg)));
    check("ascii_crc21", 32'(crc21), 32'(ref_crc(2, msg)));
    do_chk(2'd0);
    check("ascii_crc_out", crc_out, 32'h059E);
    pulse_abort();

    // Each mode (3 = reserved, behaves as CRC-15), good and corrupted CRC field.
    for (int m = 0; m < 4; m++) begin
      for (int k = 0; k < 2; k++) begin
        sm   = (m == 3) ? 0 : m;
        w    = wid(sm);
        flip = (k == 1);
        fpos = $urandom_range(w - 1);
        pulse_start();
        pay = {};
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(4) == 0) send(1'($urandom), 1'b0);
          b = 1'($urandom);
          send(b, 1'b1);
          pay.push_back(b);
        end
        do_chk(2'(m));
        exp_crc = ref_crc(sm, pay);
        check("cap_crc_out", crc_out, 32'(exp_crc));
        msg = pay;
        for (int j = 0; j < w; j++) begin
          b = exp_crc[w - 1 - j] ^ (flip && (j == fpos));
          send(b, 1'b1);
          msg.push_back(b);
          check("chk_done", 32'(done), 32'(j == w - 1));
        end
        r0 = ref_crc(sm, msg);
        check("chk_crc_ok", 32'(crc_ok), 32'(r0 == 21'd0));
        for (int s = 0; s < 3; s++) begin
          r1 = (s == sm) ? r0 : ref_crc(s, pay);
          check("chk_lfsr_hold", 32'(dut_reg(s)), 32'(r1));
        end
        check("chk_crc_out_hold", crc_out, 32'(exp_crc));
        cyc();
        check("done_pulse_end", 32'(done), 0);
        check("done_busy", 32'(busy), 0);
        check("done_ok_held", 32'(crc_ok), 32'(r0 == 21'd0));
        send(1'b1, 1'b1);
        send(1'b0, 1'b1);
        check("done_tick_ign", 32'(dut_reg(sm)), 32'(r0));
        check("done_no_redone", 32'(done), 0);
      end
    end

    // Abort in the middle of the CRC field.
    pulse_start();
    pay = {};
    for (int i = 0; i < 20; i++) begin
      b = 1'($urandom);
      send(b, 1'b1);
      pay.push_back(b);
    end
    do_chk(2'd1);
    exp_crc = ref_crc(1, pay);
    msg = pay;
    for (int j = 0; j < 10; j++) begin
      b = 1'($urandom);
      send(b, 1'b1);
      msg.push_back(b);
    end
    check("abort_pre_busy", 32'(busy), 1);
    pulse_abort();
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_crc_ok", 32'(crc_ok), 0);
    check("abort_crc17_hold", 32'(crc17), 32'(ref_crc(1, msg)));
    check("abort_crc_out_hold", crc_out, 32'(exp_crc));
    for (int j = 0; j < 10; j++) begin
      send(1'($urandom), 1'b1);
      check("abort_no_done", 32'(done), 0);
    end
    pulse_start();
    check("restart_crc17", 32'(crc17), 32'h10000);

    // chk_start coinciding with a bit tick includes that bit in the capture.
    pay = {};
    for (int i = 0; i < 16; i++) begin
      b = 1'($urandom);
      send(b, 1'b1);
      pay.push_back(b);
    end
    b = 1'($urandom);
    pay.push_back(b);
    chk_start = 1'b1; crc_sel = 2'd2; bit_tick = 1'b1; crc_enable = 1'b1; data_in = b;
    cyc();
    chk_start = 1'b0; bit_tick = 1'b0; crc_enable = 1'b0;
    check("coinc_crc_out", crc_out, 32'(ref_crc(2, pay)));
    pulse_abort();
    send(1'b1, 1'b1);
    send(1'b0, 1'b1);
    check("idle_crc15", 32'(crc15), 32'(ref_crc(0, pay)));
    check("idle_crc21", 32'(crc21), 32'(ref_crc(2, pay)));
    do_chk(2'd0);
    check("idle_chk_ign", 32'(busy), 0);

    // Synchronous reset in the middle of the CRC field.
    pulse_start();
    for (int i = 0; i < 8; i++) send(1'($urandom), 1'b1);
    do_chk(2'd1);
    for (int i = 0; i < 5; i++) send(1'($urandom), 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mrst_crc15", 32'(crc15), 0);
    check("mrst_crc17", 32'(crc17), 0);
    check("mrst_crc21", 32'(crc21), 0);
    check("mrst_crc_out", crc_out, 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_crc_ok", 32'(crc_ok), 0);
    for (int i = 0; i < 17; i++) begin
      send(1'($urandom), 1'b1);
      check("mrst_no_done", 32'(done), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
